// File: rtl/pulse_timer.sv
// ---------------------------------------------------------------------------
// pulse_timer
//   Programmable delay / refresh timebase. A Start request latches Period
//   (0 is promoted to 1) and Mode, then the block counts down one tick per
//   clock (or per PRESCALE clocks when prescaling is built in). At the
//   terminal tick it either raises Mo and holds it (one-shot, DONE state) or
//   strobes Mo for one cycle and reloads (periodic). Stop aborts to IDLE and
//   Start may retrigger from any state.
//
//   Optional build macro: PULSE_TIMER_PRESCALE_EN
//     defined   - ticks occur every PRESCALE clocks while in RUN
//     undefined - every RUN clock is a tick, PRESCALE is ignored
//
//   Ports
//     Clk    in   system clock, rising edge
//     Rst    in   synchronous active-high reset
//     Start  in   single-cycle request, latches Period/Mode
//     Stop   in   single-cycle abort to IDLE
//     Mode   in   0 = one-shot, 1 = periodic
//     Period in   [WIDTH] delay in ticks
//     Mo     out  timer output (registered)
//     Busy   out  high while in RUN (registered)
//     Count  out  [WIDTH] remaining ticks (registered)
// ---------------------------------------------------------------------------
module pulse_timer #(
    parameter int unsigned WIDTH    = 18,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Period,
    output logic             Mo,
    output logic             Busy,
    output logic [WIDTH-1:0] Count
);

    // Elaboration-time sanity check on the prescale ratio.
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("pulse_timer: PRESCALE must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] pq_q,    pq_d;      // latched, already promoted period
    logic             mode_q,  mode_d;
    logic             mo_q,    mo_d;
    logic             busy_q,  busy_d;
    logic [WIDTH-1:0] start_pq;
    logic             tick;

    // Period 0 behaves as 1 so the counter never starts at zero in RUN.
    always_comb begin
        start_pq = Period;
        if (Period == '0) start_pq = CNT_ONE;
    end

`ifdef PULSE_TIMER_PRESCALE_EN
    // A PRESCALE of 1 would give a zero-width counter; keep one bit so the
    // compare below still works (PS_LAST is then 0 and every cycle ticks).
    localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] presc_q, presc_d;

    assign tick = (presc_q == PS_LAST);

    always_comb begin
        presc_d = '0;
        // Start/Stop restart the phase; outside RUN it sits at zero.
        if (!Stop && !Start && state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + PS_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) presc_q <= '0;
        else     presc_q <= presc_d;
    end
`else
    assign tick = 1'b1;
`endif

    // Next-state and next-output logic. Stop beats Start; both beat counting.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pq_d    = pq_q;
        mode_d  = mode_q;
        mo_d    = mo_q;
        busy_d  = busy_q;

        if (Stop) begin
            state_d = ST_IDLE;
            count_d = '0;
            mo_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (Start) begin
            pq_d    = start_pq;
            mode_d  = Mode;
            count_d = start_pq;
            state_d = ST_RUN;
            busy_d  = 1'b1;
            mo_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                    mo_d    = 1'b0;
                    busy_d  = 1'b0;
                end
                ST_RUN: begin
                    busy_d = 1'b1;
                    mo_d   = 1'b0;        // periodic strobe lasts one cycle
                    if (tick) begin
                        if (count_q > CNT_ONE) begin
                            count_d = count_q - CNT_ONE;
                        end else if (mode_q) begin
                            count_d = pq_q;
                            mo_d    = 1'b1;
                        end else begin
                            count_d = '0;
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            mo_d    = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    count_d = '0;
                    mo_d    = 1'b1;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    mo_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            pq_q    <= '0;
            mode_q  <= 1'b0;
            mo_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pq_q    <= pq_d;
            mode_q  <= mode_d;
            mo_q    <= mo_d;
            busy_q  <= busy_d;
        end
    end

    assign Mo    = mo_q;
    assign Busy  = busy_q;
    assign Count = count_q;

endmodule

// File: tb/tb_pulse_timer.sv
// ---------------------------------------------------------------------------
// tb_pulse_timer
//   Drives pulse_timer one clock at a time. Each step runs a behavioural
//   model of the timer, pushes the expected Mo/Busy/Count to a scoreboard
//   queue, and pops/compares once the DUT has taken the edge. Directed
//   checks against hand-derived constants are layered on top.
// ---------------------------------------------------------------------------
module tb_pulse_timer;

    localparam int W = 8;
`ifdef PULSE_TIMER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic         Clk = 1'b0;
    logic         Rst, Start, Stop, Mode;
    logic [W-1:0] Period;
    logic         Mo, Busy;
    logic [W-1:0] Count;

    pulse_timer #(.WIDTH(W), .PRESCALE(4)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Stop(Stop), .Mode(Mode),
        .Period(Period), .Mo(Mo), .Busy(Busy), .Count(Count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic         mo;
        logic         busy;
        logic [W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // model state: 0 idle, 1 run, 2 done
    int           m_st = 0;
    int           m_ps = 0;
    logic [W-1:0] m_cnt = '0;
    logic [W-1:0] m_pq  = '0;
    logic         m_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model(input logic rst, input logic st, input logic sp,
                         input logic md, input logic [W-1:0] per, output exp_t e);
        logic strobe;
        strobe = 1'b0;
        if (rst) begin
            m_st = 0; m_cnt = '0; m_pq = '0; m_mode = 1'b0; m_ps = 0;
        end else if (sp) begin
            m_st = 0; m_cnt = '0; m_ps = 0;
        end else if (st) begin
            m_pq   = (per == '0) ? W'(1) : per;
            m_mode = md;
            m_cnt  = m_pq;
            m_st   = 1;
            m_ps   = 0;
        end else if (m_st == 1) begin
            m_ps++;
            if (m_ps == PS) begin
                m_ps = 0;
                if (m_cnt > 1)   m_cnt = m_cnt - 1'b1;
                else if (m_mode) begin m_cnt = m_pq; strobe = 1'b1; end
                else             begin m_cnt = '0; m_st = 2; end
            end
        end
        e.mo   = (m_st == 2) || strobe;
        e.busy = (m_st == 1);
        e.cnt  = m_cnt;
    endtask

    // One clock: drive inputs, predict, take the edge, compare.
    task automatic step(input logic rst, input logic st, input logic sp,
                        input logic md, input logic [W-1:0] per);
        exp_t e, got;
        Rst = rst; Start = st; Stop = sp; Mode = md; Period = per;
        model(rst, st, sp, md, per, e);
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            chk("sb_mo",   {31'd0, Mo},   {31'd0, got.mo});
            chk("sb_busy", {31'd0, Busy}, {31'd0, got.busy});
            chk("sb_cnt",  {24'd0, Count}, {24'd0, got.cnt});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        Rst = 1'b1; Start = 1'b0; Stop = 1'b0; Mode = 1'b0; Period = '0;
        #2;

        // Reset held with Start active: outputs stay zero.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, W'(5));
            chk("rst_mo", {31'd0, Mo}, 32'd0);
            chk("rst_cnt", {24'd0, Count}, 32'd0);
        end
        idle(1);
        chk("rst_rel_busy", {31'd0, Busy}, 32'd0);
        idle(8);

        // One-shot, Period 5. Period/Mode wiggle mid-run must be ignored.
        step(1'b0, 1'b1, 1'b0, 1'b0, W'(5));
        chk("os_cnt0", {24'd0, Count}, 32'd5);
        for (int i = 1; i <= 5 * PS + 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, W'(1));
            chk("os_mo", {31'd0, Mo}, (i >= 5 * PS) ? 32'd1 : 32'd0);
            chk("os_busy", {31'd0, Busy}, (i >= 5 * PS) ? 32'd0 : 32'd1);
            if (i < 5 * PS) chk("os_cnt", {24'd0, Count}, 32'(5 - i / PS));
        end
        // Stop out of DONE drops Mo.
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("done_stop_mo", {31'd0, Mo}, 32'd0);
        idle(2);

        // Periodic, Period 3.
        step(1'b0, 1'b1, 1'b0, 1'b1, W'(3));
        for (int i = 1; i <= 12 * PS + 1; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, '0);
            chk("per_mo", {31'd0, Mo}, (i % (3 * PS) == 0) ? 32'd1 : 32'd0);
            chk("per_busy", {31'd0, Busy}, 32'd1);
            chk("per_cnt", {24'd0, Count}, 32'(3 - (i % (3 * PS)) / PS));
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(2);

        // Abort after 4 edges: Mo never rises.
        step(1'b0, 1'b1, 1'b0, 1'b0, W'(10));
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("abort_cnt", {24'd0, Count}, 32'd0);
        for (int i = 0; i < 12 * PS; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, '0);
            chk("abort_mo", {31'd0, Mo}, 32'd0);
        end

        // Start and Stop together: Stop wins.
        step(1'b0, 1'b1, 1'b1, 1'b0, W'(2));
        chk("ss_busy", {31'd0, Busy}, 32'd0);
        idle(3 * PS);
        chk("ss_mo", {31'd0, Mo}, 32'd0);

        // Retrigger at Count == 2 with a shorter period.
        step(1'b0, 1'b1, 1'b0, 1'b0, W'(8));
        idle(6 * PS);
        chk("rt_cnt2", {24'd0, Count}, 32'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0, W'(4));
        chk("rt_cnt4", {24'd0, Count}, 32'd4);
        for (int i = 1; i <= 4 * PS; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, '0);
            chk("rt_mo", {31'd0, Mo}, (i == 4 * PS) ? 32'd1 : 32'd0);
        end

        // Period 0 behaves as 1 (retrigger straight from DONE).
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("p0_cnt", {24'd0, Count}, 32'd1);
        chk("p0_mo_lo", {31'd0, Mo}, 32'd0);
        idle(PS);
        chk("p0_mo", {31'd0, Mo}, 32'd1);

        // All-ones period: counts down without wrap.
        step(1'b0, 1'b1, 1'b0, 1'b0, '1);
        chk("max_cnt", {24'd0, Count}, 32'd255);
        idle(255 * PS - 1);
        chk("max_last", {24'd0, Count}, 32'd1);
        idle(1);
        chk("max_mo", {31'd0, Mo}, 32'd1);

        // Reset mid-run clears everything.
        step(1'b0, 1'b1, 1'b0, 1'b1, W'(6));
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
        idle(10);

        if (sb_q.size() != 0) chk("sb_leftover", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
